alu_sequencer: RTL and testbench

Multi-cycle controller that sequences the shared combinational ALU. It accepts one register-to-register instruction per handshake, reads both operands from an internal 16-entry register file, drives the ALU, then writes the result and flags back. It sits between the instruction source (decoder or testbench) and the `ALU` instance, which it owns exclusively.

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: opcodes, FSM states and default sizes.
package alu_seq_pkg;

  localparam int SEQ_DATA_W = 16;
  localparam int SEQ_NREGS  = 16;
  localparam int SEQ_IDX_W  = $clog2(SEQ_NREGS);
  localparam int SEQ_OP_W   = 5;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_CMP  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd6;
  localparam logic [4:0] OP_LSH  = 5'd7;
  localparam logic [4:0] OP_RSH  = 5'd8;
  localparam logic [4:0] OP_ARSH = 5'd9;
  localparam logic [4:0] OP_LAST = OP_ARSH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU sequencer: two operand read ports, a debug read port,
// one synchronous write port and an asynchronous clear.
module alu_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int NREGS  = SEQ_NREGS,
  parameter int IDX_W  = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [IDX_W-1:0]  i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic [IDX_W-1:0]  i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_rdata
);

  logic [DATA_W-1:0] r_mem [NREGS];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a   = r_mem[i_raddr_a];
  assign o_rdata_b   = r_mem[i_raddr_b];
  assign o_dbg_rdata = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state controller (IDLE/READ/EXEC/WB) that feeds an external ALU from the
// register file and writes back result and flags. Optional feature: ALU_SEQ_IMM_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int NREGS  = SEQ_NREGS,
  parameter int OP_W   = SEQ_OP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [OP_W-1:0]          instr_op,
  input  logic [$clog2(NREGS)-1:0] instr_rdest,
  input  logic [$clog2(NREGS)-1:0] instr_rsrc,
  input  logic                     instr_imm_sel,
  input  logic [7:0]               instr_imm,
  output logic [DATA_W-1:0]        alu_rsrc,
  output logic [DATA_W-1:0]        alu_rdest,
  output logic [OP_W-1:0]          alu_opcode,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic [4:0]               alu_flags,
  output logic                     done,
  output logic                     err,
  output logic [DATA_W-1:0]        result,
  output logic [4:0]               psr,
  input  logic                     dbg_we,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  input  logic [DATA_W-1:0]        dbg_wdata,
  output logic [DATA_W-1:0]        dbg_rdata
);

  localparam int IDX_W = $clog2(NREGS);

  seq_state_e        r_state, w_next;
  logic              r_ready;
  logic [OP_W-1:0]   r_op;
  logic [IDX_W-1:0]  r_rdest, r_rsrc;
  logic [DATA_W-1:0] r_alu_rdest, r_alu_rsrc, r_result;
  logic [OP_W-1:0]   r_alu_opcode;
  logic [4:0]        r_flags_pend, r_psr;

  logic              w_accept, w_legal, w_wb_we, w_psr_we, w_dbg_we;
  logic              w_done, w_err, w_rf_we;
  logic [IDX_W-1:0]  w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata, w_rd_a, w_rd_b, w_src;

  assign w_legal = (r_op <= OP_W'(OP_LAST));

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_wb_we  = 1'b0;
    w_psr_we = 1'b0;
    w_dbg_we = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_dbg_we = dbg_we;
        if (instr_valid && r_ready) begin
          w_accept = 1'b1;
          w_next   = ST_READ;
        end
      end
      ST_READ: w_next = ST_EXEC;
      ST_EXEC: w_next = ST_WB;
      ST_WB: begin
        w_done   = 1'b1;
        w_err    = ~w_legal;
        w_psr_we = w_legal;
        w_wb_we  = w_legal && (r_op != OP_W'(OP_CMP));
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Debug writes only happen in IDLE and write-back only in WB, so they never collide.
  assign w_rf_we    = w_wb_we | w_dbg_we;
  assign w_rf_waddr = w_wb_we ? r_rdest : dbg_addr;
  assign w_rf_wdata = w_wb_we ? r_result : dbg_wdata;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_we        (w_rf_we),
    .i_waddr     (w_rf_waddr),
    .i_wdata     (w_rf_wdata),
    .i_raddr_a   (r_rdest),
    .o_rdata_a   (w_rd_a),
    .i_raddr_b   (r_rsrc),
    .o_rdata_b   (w_rd_b),
    .i_dbg_addr  (dbg_addr),
    .o_dbg_rdata (dbg_rdata)
  );

`ifdef ALU_SEQ_IMM_EN
  logic       r_imm_sel;
  logic [7:0] r_imm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_imm_sel <= 1'b0;
      r_imm     <= '0;
    end else if (w_accept) begin
      r_imm_sel <= instr_imm_sel;
      r_imm     <= instr_imm;
    end
  end

  assign w_src = r_imm_sel ? {{(DATA_W-8){r_imm[7]}}, r_imm} : w_rd_b;
`else
  logic w_unused_imm;
  assign w_unused_imm = ^{instr_imm_sel, instr_imm};
  assign w_src        = w_rd_b;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b0;
      r_op         <= '0;
      r_rdest      <= '0;
      r_rsrc       <= '0;
      r_alu_rdest  <= '0;
      r_alu_rsrc   <= '0;
      r_alu_opcode <= OP_W'(OP_ADD);
      r_result     <= '0;
      r_flags_pend <= '0;
      r_psr        <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE);
      if (w_accept) begin
        r_op    <= instr_op;
        r_rdest <= instr_rdest;
        r_rsrc  <= instr_rsrc;
      end
      if (r_state == ST_READ) begin
        r_alu_rdest  <= w_rd_a;
        r_alu_rsrc   <= w_src;
        r_alu_opcode <= r_op;
      end
      if (r_state == ST_EXEC) begin
        r_result     <= alu_out;
        r_flags_pend <= alu_flags;
      end
      if (w_psr_we) r_psr <= r_flags_pend;
    end
  end

  assign instr_ready = r_ready;
  assign alu_rdest   = r_alu_rdest;
  assign alu_rsrc    = r_alu_rsrc;
  assign alu_opcode  = r_alu_opcode;
  assign result      = r_result;
  assign psr         = r_psr;
  assign done        = w_done;
  assign err         = w_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU; ALU_SEQ_IMM_EN selects the immediate expectation.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, instr_ready;
  logic [4:0]  instr_op;
  logic [3:0]  instr_rdest, instr_rsrc;
  logic        instr_imm_sel;
  logic [7:0]  instr_imm;
  logic [15:0] alu_rsrc, alu_rdest, alu_out;
  logic [4:0]  alu_opcode, alu_flags;
  logic        done, err;
  logic [15:0] result;
  logic [4:0]  psr;
  logic        dbg_we;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_wdata, dbg_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk (clk), .reset (reset),
    .instr_valid (instr_valid), .instr_ready (instr_ready), .instr_op (instr_op),
    .instr_rdest (instr_rdest), .instr_rsrc (instr_rsrc),
    .instr_imm_sel (instr_imm_sel), .instr_imm (instr_imm),
    .alu_rsrc (alu_rsrc), .alu_rdest (alu_rdest), .alu_opcode (alu_opcode),
    .alu_out (alu_out), .alu_flags (alu_flags),
    .done (done), .err (err), .result (result), .psr (psr),
    .dbg_we (dbg_we), .dbg_addr (dbg_addr), .dbg_wdata (dbg_wdata), .dbg_rdata (dbg_rdata)
  );

  // Behavioural ALU: flags = {2'b00, carry, negative, zero}; shifts are by one on Rsrc.
  logic        m_c;
  logic [15:0] m_res;
  always_comb begin
    m_c   = 1'b0;
    m_res = 16'h0000;
    case (alu_opcode)
      5'd0:       {m_c, m_res} = {1'b0, alu_rdest} + {1'b0, alu_rsrc};
      5'd1, 5'd2: {m_c, m_res} = {1'b0, alu_rdest} - {1'b0, alu_rsrc};
      5'd3:       m_res = alu_rdest & alu_rsrc;
      5'd4:       m_res = alu_rdest | alu_rsrc;
      5'd5:       m_res = alu_rdest ^ alu_rsrc;
      5'd6:       m_res = ~alu_rsrc;
      5'd7:       {m_c, m_res} = {alu_rsrc, 1'b0};
      5'd8:       begin m_res = {1'b0, alu_rsrc[15:1]};        m_c = alu_rsrc[0]; end
      5'd9:       begin m_res = {alu_rsrc[15], alu_rsrc[15:1]}; m_c = alu_rsrc[0]; end
      default:    m_res = 16'h0000;
    endcase
    alu_out   = m_res;
    alu_flags = {2'b00, m_c, m_res[15], (m_res == 16'h0000)};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic dbg_wr(input logic [3:0] a, input logic [15:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(posedge clk); #1;
    dbg_we = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_rdata;
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic isel, input logic [7:0] imm);
    int n = 0;
    while (!instr_ready && n < 10) begin @(posedge clk); #1; n++; end
    chk("ready_before_issue", 32'(instr_ready), 32'd1);
    instr_op = op; instr_rdest = rd; instr_rsrc = rs;
    instr_imm_sel = isel; instr_imm = imm; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  // Returns the number of edges after accept at which done was seen (-1 if never),
  // the err/result seen alongside it, and advances past the commit edge.
  task automatic wait_done(output int lat, output logic e, output logic [15:0] res);
    lat = -1; e = 1'b0; res = 16'h0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; e = err; res = result; break; end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  rd, rs;
    logic [15:0] a, b, exp_rd, exp_res;
    logic [4:0]  exp_psr;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[12];
  logic [4:0]  model_psr;
  int          lat;
  logic        e;
  logic [15:0] res, v;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{5'd0,  4'd1,  4'd2,  16'h1234, 16'h0001, 16'h1235, 16'h1235, 5'b00000, 1'b0};
    vecs[1]  = '{5'd0,  4'd1,  4'd2,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b00101, 1'b0};
    vecs[2]  = '{5'd1,  4'd3,  4'd4,  16'h0003, 16'h0005, 16'hFFFE, 16'hFFFE, 5'b00110, 1'b0};
    vecs[3]  = '{5'd3,  4'd2,  4'd1,  16'h0F0F, 16'h00F0, 16'h0000, 16'h0000, 5'b00001, 1'b0};
    vecs[4]  = '{5'd4,  4'd8,  4'd9,  16'h8000, 16'h0001, 16'h8001, 16'h8001, 5'b00010, 1'b0};
    vecs[5]  = '{5'd5,  4'd5,  4'd1,  16'hAF0C, 16'h00F0, 16'hAFFC, 16'hAFFC, 5'b00010, 1'b0};
    vecs[6]  = '{5'd6,  4'd10, 4'd11, 16'h1234, 16'h00FF, 16'hFF00, 16'hFF00, 5'b00010, 1'b0};
    vecs[7]  = '{5'd8,  4'd12, 4'd13, 16'h0000, 16'h8003, 16'h4001, 16'h4001, 5'b00100, 1'b0};
    vecs[8]  = '{5'd9,  4'd12, 4'd13, 16'h0000, 16'h8002, 16'hC001, 16'hC001, 5'b00010, 1'b0};
    vecs[9]  = '{5'd2,  4'd3,  4'd4,  16'h0005, 16'h0005, 16'h0005, 16'h0000, 5'b00001, 1'b0};
    vecs[10] = '{5'd12, 4'd14, 4'd15, 16'h1111, 16'h2222, 16'h1111, 16'h0000, 5'b00000, 1'b1};
    vecs[11] = '{5'd0,  4'd6,  4'd6,  16'h0101, 16'h0101, 16'h0202, 16'h0202, 5'b00000, 1'b0};

    reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rdest = '0; instr_rsrc = '0;
    instr_imm_sel = 1'b0; instr_imm = '0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    model_psr = 5'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(instr_ready), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_psr", 32'(psr), 32'd0);
    chk("reset_opcode", 32'(alu_opcode), 32'd0);
    chk("reset_regs", 32'(dbg_rdata), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_release", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_first_edge", 32'(instr_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      dbg_wr(vecs[i].rd, vecs[i].a);
      dbg_wr(vecs[i].rs, vecs[i].b);
      issue(vecs[i].op, vecs[i].rd, vecs[i].rs, 1'b0, 8'h00);
      wait_done(lat, e, res);
      if (!vecs[i].exp_err) model_psr = vecs[i].exp_psr;
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_psr", i), 32'(psr), 32'(model_psr));
      rd_reg(vecs[i].rd, v);
      chk($sformatf("v%0d_rdest", i), 32'(v), 32'(vecs[i].exp_rd));
    end

    // Dependent back-to-back: XOR R5=R5^R1 then LSH R6 <- R5, offered immediately.
    dbg_wr(4'd5, 16'hAF0C);
    dbg_wr(4'd1, 16'h00F0);
    issue(5'd5, 4'd5, 4'd1, 1'b0, 8'h00);
    instr_op = 5'd7; instr_rdest = 4'd6; instr_rsrc = 4'd5; instr_valid = 1'b1;
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (instr_ready) begin lat = n; break; end
    end
    chk("b2b_cadence", 32'(lat), 32'd3);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wait_done(lat, e, res);
    chk("b2b_latency", 32'(lat), 32'd2);
    rd_reg(4'd6, v);
    chk("b2b_r6", 32'(v), 32'h5FF8);
    rd_reg(4'd5, v);
    chk("b2b_r5", 32'(v), 32'hAFFC);

    // Immediate operand.
    dbg_wr(4'd7, 16'h0001);
    dbg_wr(4'd2, 16'h0010);
    issue(5'd0, 4'd7, 4'd2, 1'b1, 8'hFF);
    wait_done(lat, e, res);
    rd_reg(4'd7, v);
`ifdef ALU_SEQ_IMM_EN
    chk("imm_r7", 32'(v), 32'h0000);
    chk("imm_psr", 32'(psr), 32'b00101);
`else
    chk("imm_r7", 32'(v), 32'h0011);
    chk("imm_psr", 32'(psr), 32'b00000);
`endif

    // Debug write and accept in the same cycle; later debug writes outside IDLE are dropped.
    dbg_wr(4'd10, 16'hFF00);
    dbg_we = 1'b1; dbg_addr = 4'd9; dbg_wdata = 16'h0040;
    instr_op = 5'd0; instr_rdest = 4'd9; instr_rsrc = 4'd9; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    dbg_addr = 4'd10; dbg_wdata = 16'hDEAD;
    wait_done(lat, e, res);
    dbg_we = 1'b0;
    chk("dbg_same_cycle_result", 32'(res), 32'h0080);
    rd_reg(4'd9, v);
    chk("dbg_same_cycle_r9", 32'(v), 32'h0080);
    rd_reg(4'd10, v);
    chk("dbg_busy_ignored", 32'(v), 32'hFF00);

    // Reset in the middle of EXEC aborts the ADD.
    dbg_wr(4'd1, 16'h0007);
    dbg_wr(4'd2, 16'h0003);
    issue(5'd0, 4'd1, 4'd2, 1'b0, 8'h00);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(instr_ready), 32'd0);
    chk("midrst_psr", 32'(psr), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    chk("midrst_ready_held", 32'(instr_ready), 32'd0);
    rd_reg(4'd1, v);
    chk("midrst_r1", 32'(v), 32'h0000);
    reset = 1'b0;
    #1;
    chk("midrst_ready_release", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_ready_edge", 32'(instr_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done), 32'd0);
    rd_reg(4'd1, v);
    chk("midrst_r1_after", 32'(v), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
